// File: rtl/olimp_pkg.sv
// Shared constants and types for the OLIMP vector MAC sequencer:
// custom-0 opcode, funct3 operation codes, FSM state encoding and
// the per-chunk memory strides.
package olimp_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    localparam logic [2:0] F3_MACC  = 3'b000;  // acc0 + acc1
    localparam logic [2:0] F3_MACC0 = 3'b001;  // acc0 only
    localparam logic [2:0] F3_MACC1 = 3'b010;  // acc1 only
    localparam logic [2:0] F3_MACZ  = 3'b011;  // ReLU(acc0 + acc1), optional

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One vector chunk occupies 8 bytes of data and 16 bytes of coefficients.
    localparam int DATA_STRIDE = 8;
    localparam int COEF_STRIDE = 16;

endpackage

// File: rtl/olimp_macc_addr_gen.sv
// Address generator for the OLIMP MAC sequencer. Loads the data and
// coefficient base addresses, advances both by their chunk strides on
// each step (wrapping at the port widths) and flags the last chunk.
module olimp_macc_addr_gen
    import olimp_pkg::*;
#(
    parameter int DATA_AW = 17,
    parameter int COEF_AW = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               step,
    input  logic [DATA_AW-1:0] base_d,
    input  logic [COEF_AW-1:0] base_c,
    input  logic [7:0]         n_chunks,
    output logic [DATA_AW-1:0] dm_addr,
    output logic [COEF_AW-1:0] cm_addr,
    output logic               last
);

    logic [7:0] chunk_idx;
    logic [7:0] last_idx;

    // Base load on launch, stride increment per issued chunk.
    // N=0 becomes last_idx=255, i.e. 256 chunks, through 8-bit wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dm_addr   <= '0;
            cm_addr   <= '0;
            chunk_idx <= '0;
            last_idx  <= '0;
        end else if (load) begin
            dm_addr   <= base_d;
            cm_addr   <= base_c;
            chunk_idx <= '0;
            last_idx  <= n_chunks - 8'd1;
        end else if (step) begin
            dm_addr   <= dm_addr + DATA_AW'(DATA_STRIDE);
            cm_addr   <= cm_addr + COEF_AW'(COEF_STRIDE);
            chunk_idx <= chunk_idx + 8'd1;
        end
    end

    assign last = (chunk_idx == last_idx);

endmodule

// File: rtl/olimp_macc_seq.sv
// PCPI-attached sequencer for the OLIMP vector MAC datapath. One custom-0
// instruction walks N chunks of data/coefficient memory, accumulates the
// datapath's two partial sums and returns the result to picorv32.
// Optional feature: define OLIMP_MACC_RELU_EN to claim funct3=011 (MACZ),
// which clamps a negative wrapped acc0+acc1 to zero.
module olimp_macc_seq
    import olimp_pkg::*;
#(
    parameter int DATA_AW = 17,
    parameter int COEF_AW = 15,
    parameter int LAT     = 2
) (
    input  logic               clk_cpu,
    input  logic               resetn,
    input  logic               pcpi_valid,
    input  logic [31:0]        pcpi_insn,
    input  logic [31:0]        pcpi_rs1,
    input  logic [31:0]        pcpi_rs2,
    output logic               pcpi_wr,
    output logic [31:0]        pcpi_rd,
    output logic               pcpi_wait,
    output logic               pcpi_ready,
    output logic [DATA_AW-1:0] dm_addr,
    output logic [COEF_AW-1:0] cm_addr,
    output logic               dp_sel,
    input  logic [31:0]        acc0_in,
    input  logic [31:0]        acc1_in
);

    // PCPI handshake: the core holds pcpi_valid with a stable instruction
    // until it sees pcpi_ready. We raise pcpi_wait combinationally in the
    // cycle we claim and keep it up in every busy state; pcpi_ready and
    // pcpi_wr pulse together for exactly one cycle with pcpi_rd valid.
    // Dropping pcpi_valid while busy aborts without a ready pulse. The
    // guard flag masks the stale pcpi_valid the core holds the cycle
    // after ready so the same instruction is not launched twice.

    state_t      state;
    state_t      state_next;
    logic [LAT-1:0] tag_pipe;
    logic [LAT-1:0] tag_next;
    logic [LAT-1:0] tag_rest;
    logic [31:0] acc0;
    logic [31:0] acc1;
    logic [31:0] sum;
    logic [31:0] result;
    logic [2:0]  f3_q;
    logic        guard;
    logic        claim;
    logic        launch;
    logic        last;
    logic        tag_out;
    logic        unused_bits;

    assign unused_bits = ^{pcpi_rs1[23:DATA_AW], pcpi_rs2[31:COEF_AW],
                           pcpi_insn[24:15], pcpi_insn[11:7]};

    // Instruction decode: custom-0 opcode, funct7 zero, supported funct3.
    always_comb begin
        claim = 1'b0;
        if (pcpi_insn[6:0] == OPC_CUSTOM0 && pcpi_insn[31:25] == 7'd0) begin
            case (pcpi_insn[14:12])
                F3_MACC, F3_MACC0, F3_MACC1: claim = 1'b1;
`ifdef OLIMP_MACC_RELU_EN
                F3_MACZ: claim = 1'b1;
`endif
                default: claim = 1'b0;
            endcase
        end
    end

    assign launch   = (state == IDLE) && pcpi_valid && claim && !guard;
    assign tag_out  = tag_pipe[LAT-1];
    // Pipe contents that remain after this cycle's shift.
    assign tag_rest = tag_pipe << 1;

    olimp_macc_addr_gen #(
        .DATA_AW (DATA_AW),
        .COEF_AW (COEF_AW)
    ) u_addr_gen (
        .clk      (clk_cpu),
        .resetn   (resetn),
        .load     (launch),
        .step     ((state == ISSUE) && !last),
        .base_d   (pcpi_rs1[DATA_AW-1:0]),
        .base_c   (pcpi_rs2[COEF_AW-1:0]),
        .n_chunks (pcpi_rs1[31:24]),
        .dm_addr  (dm_addr),
        .cm_addr  (cm_addr),
        .last     (last)
    );

    // Next-state logic and the tag value shifted in this cycle.
    always_comb begin
        state_next  = state;
        tag_next    = tag_pipe << 1;
        tag_next[0] = (state == ISSUE);
        case (state)
            IDLE:  if (launch) state_next = ISSUE;
            ISSUE: begin
                if (!pcpi_valid) state_next = IDLE;
                else if (last)   state_next = DRAIN;
            end
            DRAIN: begin
                if (!pcpi_valid)        state_next = IDLE;
                else if (tag_rest == '0) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result selection from the latched funct3; all sums wrap at 32 bits.
    always_comb begin
        sum = acc0 + acc1;
        case (f3_q)
            F3_MACC0: result = acc0;
            F3_MACC1: result = acc1;
`ifdef OLIMP_MACC_RELU_EN
            F3_MACZ:  result = sum[31] ? 32'd0 : sum;
`endif
            default:  result = sum;
        endcase
    end

    // State register, tag pipe, accumulators and relaunch guard.
    always_ff @(posedge clk_cpu) begin
        if (!resetn) begin
            state    <= IDLE;
            tag_pipe <= '0;
            acc0     <= '0;
            acc1     <= '0;
            f3_q     <= '0;
            guard    <= 1'b0;
        end else begin
            state <= state_next;
            guard <= (state == DONE);
            if (launch) begin
                tag_pipe <= '0;
                acc0     <= '0;
                acc1     <= '0;
                f3_q     <= pcpi_insn[14:12];
            end else if (state == ISSUE || state == DRAIN) begin
                tag_pipe <= tag_next;
                if (tag_out) begin
                    acc0 <= acc0 + acc0_in;
                    acc1 <= acc1 + acc1_in;
                end
            end else begin
                tag_pipe <= '0;
            end
        end
    end

    assign pcpi_wait  = (state != IDLE) || launch;
    assign pcpi_ready = (state == DONE);
    assign pcpi_wr    = (state == DONE);
    assign pcpi_rd    = (state == DONE) ? result : 32'd0;
    assign dp_sel     = (state == ISSUE) || (state == DRAIN);

endmodule

// File: tb/tb_olimp_macc_seq.sv
// Directed testbench for olimp_macc_seq with LAT=2. Each task drives one
// scenario and compares against hand-computed values. Expectations for
// MACZ follow the OLIMP_MACC_RELU_EN macro.
module tb_olimp_macc_seq;

    localparam int DATA_AW = 17;
    localparam int COEF_AW = 15;
    localparam int LAT     = 2;

    localparam logic [31:0] I_MACC  = 32'h0000_000B;
    localparam logic [31:0] I_MACC0 = 32'h0000_100B;
    localparam logic [31:0] I_MACC1 = 32'h0000_200B;
    localparam logic [31:0] I_MACZ  = 32'h0000_300B;

    logic               clk_cpu = 1'b0;
    logic               resetn;
    logic               pcpi_valid;
    logic [31:0]        pcpi_insn;
    logic [31:0]        pcpi_rs1;
    logic [31:0]        pcpi_rs2;
    logic               pcpi_wr;
    logic [31:0]        pcpi_rd;
    logic               pcpi_wait;
    logic               pcpi_ready;
    logic [DATA_AW-1:0] dm_addr;
    logic [COEF_AW-1:0] cm_addr;
    logic               dp_sel;
    logic [31:0]        acc0_in;
    logic [31:0]        acc1_in;

    int checks   = 0;
    int failures = 0;

    logic [DATA_AW-1:0] dm_log [0:15];
    logic [COEF_AW-1:0] cm_log [0:15];
    logic               sel_log[0:15];

    olimp_macc_seq #(
        .DATA_AW (DATA_AW),
        .COEF_AW (COEF_AW),
        .LAT     (LAT)
    ) dut (
        .clk_cpu    (clk_cpu),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready),
        .dm_addr    (dm_addr),
        .cm_addr    (cm_addr),
        .dp_sel     (dp_sel),
        .acc0_in    (acc0_in),
        .acc1_in    (acc1_in)
    );

    // clock / reset
    always #5 clk_cpu = ~clk_cpu;

    // Driver: launch in cycle 0, watch for ready up to max_cyc cycles,
    // keep pcpi_valid high through the cycle after ready, then release.
    task automatic do_op(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] a0,
                         input logic [31:0] a1, input int max_cyc,
                         output logic wait0, output int ready_cyc,
                         output logic [31:0] rd, output logic wr,
                         output logic wait_after, output int pulses);
        @(negedge clk_cpu);
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        acc0_in    = a0;
        acc1_in    = a1;
        pcpi_valid = 1'b1;
        #1;
        wait0      = pcpi_wait;
        ready_cyc  = -1;
        rd         = '0;
        wr         = 1'b0;
        wait_after = 1'b1;
        pulses     = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk_cpu);
            if (c < 16) begin
                dm_log[c]  = dm_addr;
                cm_log[c]  = cm_addr;
                sel_log[c] = dp_sel;
            end
            if (pcpi_ready) begin
                ready_cyc = c;
                rd        = pcpi_rd;
                wr        = pcpi_wr;
                pulses    = 1;
                break;
            end
        end
        if (ready_cyc > 0) begin
            @(negedge clk_cpu);
            wait_after = pcpi_wait;
            if (pcpi_ready) pulses++;
            @(posedge clk_cpu);
            #1;
            pcpi_valid = 1'b0;
            repeat (3) begin
                @(negedge clk_cpu);
                if (pcpi_ready) pulses++;
            end
        end else begin
            pcpi_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        pcpi_insn  = '0;
        pcpi_rs1   = '0;
        pcpi_rs2   = '0;
        acc0_in    = '0;
        acc1_in    = '0;
        repeat (3) @(posedge clk_cpu);
        @(negedge clk_cpu);
        checks++;
        if ({pcpi_ready, pcpi_wr, pcpi_wait, dp_sel} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {pcpi_ready, pcpi_wr, pcpi_wait, dp_sel});
        end
        checks++;
        if (pcpi_rd !== 32'd0) begin
            failures++;
            $display("FAIL reset_rd got=%h exp=0", pcpi_rd);
        end
        checks++;
        if (dm_addr !== '0 || cm_addr !== '0) begin
            failures++;
            $display("FAIL reset_addr got dm=%h cm=%h exp=0/0", dm_addr, cm_addr);
        end
        resetn = 1'b1;
    endtask

    task automatic test_macc_basic();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        do_op(I_MACC, {8'd4, 24'h0}, 32'h0, 32'd8, 32'd8, 20, w0, rc, rd, wr, wa, pl);
        checks++;
        if (w0 !== 1'b1) begin
            failures++;
            $display("FAIL macc_wait_cycle0 got=%b exp=1", w0);
        end
        checks++;
        if (rc != 7) begin
            failures++;
            $display("FAIL macc_ready_cycle got=%0d exp=7", rc);
        end
        checks++;
        if (rd !== 32'd64 || wr !== 1'b1) begin
            failures++;
            $display("FAIL macc_result got rd=%h wr=%b exp rd=40 wr=1", rd, wr);
        end
        checks++;
        if (pl != 1) begin
            failures++;
            $display("FAIL macc_one_pulse got=%0d exp=1", pl);
        end
        checks++;
        if (wa !== 1'b0) begin
            failures++;
            $display("FAIL no_relaunch_wait got=%b exp=0", wa);
        end
    endtask

    task automatic test_addr_macc0();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        logic [DATA_AW-1:0] exp_dm[1:3];
        logic [COEF_AW-1:0] exp_cm[1:3];
        exp_dm[1] = 17'h00100; exp_dm[2] = 17'h00108; exp_dm[3] = 17'h00110;
        exp_cm[1] = 15'h0040;  exp_cm[2] = 15'h0050;  exp_cm[3] = 15'h0060;
        do_op(I_MACC0, {8'd3, 24'h000100}, 32'h40, 32'd5, 32'd99, 20,
              w0, rc, rd, wr, wa, pl);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (dm_log[c] !== exp_dm[c] || cm_log[c] !== exp_cm[c] || sel_log[c] !== 1'b1) begin
                failures++;
                $display("FAIL addr_cycle%0d got dm=%h cm=%h sel=%b exp dm=%h cm=%h sel=1",
                         c, dm_log[c], cm_log[c], sel_log[c], exp_dm[c], exp_cm[c]);
            end
        end
        checks++;
        if (rc != 6 || rd !== 32'd15) begin
            failures++;
            $display("FAIL macc0_result got cyc=%0d rd=%h exp cyc=6 rd=f", rc, rd);
        end
    endtask

    task automatic test_macc1();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        do_op(I_MACC1, {8'd2, 24'h0}, 32'h0, 32'd100, 32'hFFFF_FFFD, 20,
              w0, rc, rd, wr, wa, pl);
        checks++;
        if (rc != 5 || rd !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL macc1_result got cyc=%0d rd=%h exp cyc=5 rd=fffffffa", rc, rd);
        end
    endtask

    task automatic test_wrap();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        do_op(I_MACC, {8'd1, 24'h0}, 32'h0, 32'h7FFF_FFFF, 32'd1, 20,
              w0, rc, rd, wr, wa, pl);
        checks++;
        if (rc != 4 || rd !== 32'h8000_0000) begin
            failures++;
            $display("FAIL sum_wrap got cyc=%0d rd=%h exp cyc=4 rd=80000000", rc, rd);
        end
        do_op(I_MACC, {8'd2, 24'h01FFF8}, 32'h7FF0, 32'd0, 32'd0, 20,
              w0, rc, rd, wr, wa, pl);
        checks++;
        if (dm_log[1] !== 17'h1FFF8 || dm_log[2] !== 17'h00000) begin
            failures++;
            $display("FAIL dm_wrap got %h/%h exp 1fff8/00000", dm_log[1], dm_log[2]);
        end
        checks++;
        if (cm_log[1] !== 15'h7FF0 || cm_log[2] !== 15'h0000) begin
            failures++;
            $display("FAIL cm_wrap got %h/%h exp 7ff0/0000", cm_log[1], cm_log[2]);
        end
    endtask

    task automatic test_n_zero();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        do_op(I_MACC, 32'h0, 32'h0, 32'd1, 32'd2, 300, w0, rc, rd, wr, wa, pl);
        checks++;
        if (rc != 259 || rd !== 32'h0000_0300) begin
            failures++;
            $display("FAIL n_zero got cyc=%0d rd=%h exp cyc=259 rd=300", rc, rd);
        end
    endtask

    task automatic test_macz();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        do_op(I_MACZ, {8'd1, 24'h0}, 32'h0, 32'hFFFF_FFFB, 32'd2, 10,
              w0, rc, rd, wr, wa, pl);
`ifdef OLIMP_MACC_RELU_EN
        checks++;
        if (rc != 4 || rd !== 32'd0 || w0 !== 1'b1) begin
            failures++;
            $display("FAIL macz_relu got cyc=%0d rd=%h wait=%b exp cyc=4 rd=0 wait=1", rc, rd, w0);
        end
`else
        checks++;
        if (w0 !== 1'b0 || rc != -1) begin
            failures++;
            $display("FAIL macz_unclaimed got wait=%b cyc=%0d exp wait=0 cyc=-1", w0, rc);
        end
`endif
    endtask

    task automatic test_unclaimed();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        logic [31:0] bad[0:2];
        bad[0] = 32'h0200_000B;  // funct7 nonzero
        bad[1] = 32'h0000_400B;  // funct3 100
        bad[2] = 32'h0000_0033;  // OP opcode
        for (int i = 0; i < 3; i++) begin
            do_op(bad[i], {8'd1, 24'h0}, 32'h0, 32'd1, 32'd1, 8, w0, rc, rd, wr, wa, pl);
            checks++;
            if (w0 !== 1'b0 || rc != -1) begin
                failures++;
                $display("FAIL unclaimed_%0d got wait=%b cyc=%0d exp wait=0 cyc=-1", i, w0, rc);
            end
        end
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk_cpu);
        pcpi_insn  = I_MACC;
        pcpi_rs1   = {8'd8, 24'h0};
        pcpi_rs2   = 32'h0;
        acc0_in    = 32'd1;
        acc1_in    = 32'd1;
        pcpi_valid = 1'b1;
        @(negedge clk_cpu);
        checks++;
        if (dp_sel !== 1'b1 || pcpi_wait !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy got sel=%b wait=%b exp 1/1", dp_sel, pcpi_wait);
        end
        @(negedge clk_cpu);
        pcpi_valid = 1'b0;
        @(negedge clk_cpu);
        checks++;
        if (dp_sel !== 1'b0 || pcpi_wait !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got sel=%b wait=%b exp 0/0", dp_sel, pcpi_wait);
        end
        seen = 0;
        repeat (15) begin
            @(negedge clk_cpu);
            if (pcpi_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_ready got=%0d exp=0", seen);
        end
    endtask

    task automatic test_reset_mid_drain();
        int seen;
        @(negedge clk_cpu);
        pcpi_insn  = I_MACC;
        pcpi_rs1   = {8'd1, 24'h000200};
        pcpi_rs2   = 32'h100;
        acc0_in    = 32'd7;
        acc1_in    = 32'd7;
        pcpi_valid = 1'b1;
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        checks++;
        if (dp_sel !== 1'b1 || pcpi_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_state got sel=%b ready=%b exp 1/0", dp_sel, pcpi_ready);
        end
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        @(negedge clk_cpu);
        checks++;
        if ({pcpi_ready, pcpi_wr, pcpi_wait, dp_sel} !== 4'b0000 || pcpi_rd !== 32'd0
            || dm_addr !== '0 || cm_addr !== '0) begin
            failures++;
            $display("FAIL reset_mid_drain got flags=%b rd=%h dm=%h cm=%h exp 0000/0/0/0",
                     {pcpi_ready, pcpi_wr, pcpi_wait, dp_sel}, pcpi_rd, dm_addr, cm_addr);
        end
        resetn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk_cpu);
            if (pcpi_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_no_ready got=%0d exp=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic w0, wr, wa;
        int rc, pl;
        logic [31:0] rd;
        do_op(I_MACC, {8'd2, 24'h0}, 32'h0, 32'd3, 32'd4, 20, w0, rc, rd, wr, wa, pl);
        checks++;
        if (rc != 5 || rd !== 32'd14 || pl != 1) begin
            failures++;
            $display("FAIL b2b_first got cyc=%0d rd=%h pulses=%0d exp 5/e/1", rc, rd, pl);
        end
        do_op(I_MACC1, {8'd5, 24'h0}, 32'h0, 32'd9, 32'hFFFF_FFFF, 20,
              w0, rc, rd, wr, wa, pl);
        checks++;
        if (rc != 8 || rd !== 32'hFFFF_FFFB || pl != 1) begin
            failures++;
            $display("FAIL b2b_second got cyc=%0d rd=%h pulses=%0d exp 8/fffffffb/1", rc, rd, pl);
        end
    endtask

    initial begin
        test_reset();
        test_macc_basic();
        test_addr_macc0();
        test_macc1();
        test_wrap();
        test_n_zero();
        test_macz();
        test_unclaimed();
        test_abort();
        test_reset_mid_drain();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/olimp_macc_seq.md
# olimp_macc_seq

PCPI-attached sequencer for the OLIMP vector MAC datapath on the icebreaker SoC. On a custom instruction it walks the data and coefficient memories over N consecutive vector chunks and drives their shared address ports. It accumulates the datapath's two per-chunk partial sums, `acc0` and `acc1`, and returns the result to picorv32 through the PCPI handshake. This replaces the single-shot two-stage PCPI process, so one instruction covers a whole dot product.

## Interface
- `DATA_AW`, 17: data memory byte-address width.
- `COEF_AW`, 15: coefficient memory byte-address width.
- `LAT`, 2: cycles from address issue to valid `acc0_in`/`acc1_in`. Legal range 1..8.

Ports:
- `clk_cpu` in 1: the only clock.
- `resetn` in 1: synchronous, active-low reset.
- `pcpi_valid` in 1: PCPI request.
- `pcpi_insn` in 32: instruction word.
- `pcpi_rs1` in 32: `[DATA_AW-1:0]` is the data base address; `[31:24]` is the chunk count N.
- `pcpi_rs2` in 32: `[COEF_AW-1:0]` is the coefficient base address.
- `pcpi_wr` out 1: write `pcpi_rd` to rd.
- `pcpi_rd` out 32: result.
- `pcpi_wait` out 1: instruction claimed, busy.
- `pcpi_ready` out 1: result valid.
- `dm_addr` out `DATA_AW`: data memory address.
- `cm_addr` out `COEF_AW`: coefficient memory address.
- `dp_sel` out 1: 1 means the memory address muxes take `dm_addr`/`cm_addr` instead of `mem_addr`.
- `acc0_in` in 32: signed partial sum for lane group 0.
- `acc1_in` in 32: signed partial sum for lane group 1.

## Operation
- Decode: an instruction is claimed only when opcode is 7'b0001011 (custom-0), funct7 is 0, and funct3 is one of:
  - 000 MACC: result = acc0+acc1.
  - 001 MACC0: result = acc0.
  - 010 MACC1: result = acc1.
  - 011 MACZ: only with the configuration macro, see Configuration.
- Any other encoding is left unclaimed: `pcpi_wait`=0, no ready.
- N=0 is interpreted as 256 chunks.
- FSM states and transitions:
  - IDLE → ISSUE: on `pcpi_valid` & claim & !`guard`. Latch bases, N and funct3; clear both accumulators and the tag pipe.
  - ISSUE: each cycle drive chunk k, with `dm_addr`=base_d+8k and `cm_addr`=base_c+16k. Push a 1 into the `LAT`-deep tag pipe. After chunk N-1 is issued, go to DRAIN.
  - DRAIN: push 0s into the tag pipe. Go to DONE once the pipe is empty.
  - DONE: `pcpi_ready`=1 and `pcpi_wr`=1 for one cycle, `pcpi_rd`=result. Set `guard`, return to IDLE.
- Accumulation: whenever the pipe output tag is 1, acc0+=`acc0_in` and acc1+=`acc1_in`.
  - 32-bit two's complement; overflow wraps with no saturation.
  - The result sum also wraps to 32 bits.
- Address arithmetic wraps modulo 2^`DATA_AW` and 2^`COEF_AW`.
- `guard` clears one cycle after it is set. This blocks relaunch on the stale `pcpi_valid` that picorv32 holds in the cycle after ready.
- `dp_sel`=1 in ISSUE and DRAIN, 0 otherwise.
- `pcpi_wait`=1 in every non-IDLE state. It is also 1 in the IDLE cycle in which a claim is accepted.
- Abort: if `pcpi_valid` falls in ISSUE or DRAIN, go to IDLE next cycle. No ready is issued, the accumulators are discarded, and `dp_sel` drops.

## Timing
- Reset values: `pcpi_ready`=0, `pcpi_wr`=0, `pcpi_wait`=0, `pcpi_rd`=0, `dp_sel`=0, `dm_addr`=0, `cm_addr`=0, state IDLE, accumulators 0, tag pipe 0, `guard`=0.
- Reset mid-operation returns to IDLE on the next edge; no ready is issued.
- Latency: take the IDLE acceptance edge as cycle 0.
  - Chunks are issued in cycles 1..N.
  - The last accumulate is registered at the end of cycle N+`LAT`.
  - `pcpi_ready` is high in cycle N+`LAT`+1.
- Addresses are registered outputs; the chunk-k address is stable for the whole of cycle k+1.
- Throughput is one chunk per cycle with no bubbles.

## Configuration
- Macro `OLIMP_MACC_RELU_EN`.
- Defined: funct3=011 (MACZ) is claimed, with result = (acc0+acc1)<0 ? 0 : acc0+acc1. The comparison uses the wrapped 32-bit sum.
- Undefined: funct3=011 is unclaimed and no ReLU logic is built.

## Structure
- Package `olimp_pkg` holds:
  - the custom-0 opcode constant;
  - the funct3 codes MACC, MACC0, MACC1 and MACZ;
  - the FSM state enum {IDLE, ISSUE, DRAIN, DONE};
  - the chunk strides, 8 for data and 16 for coefficients.
- One sub-module, `olimp_macc_addr_gen`: base load, per-cycle stride increment, chunk counter, and a last-chunk flag.
- The tag pipe and accumulators stay in the top module.

## Test plan
- MACC, N=4, `LAT`=2, datapath returning `acc0_in`=8 and `acc1_in`=8 every tagged cycle → `pcpi_rd`=64, `pcpi_wr`=1, ready in cycle 7, exactly one ready pulse.
- MACC0, N=3, base_d=0x100, base_c=0x40 → `dm_addr` 0x100/0x108/0x110 and `cm_addr` 0x40/0x50/0x60 in cycles 1..3; `pcpi_rd`=3·`acc0_in`.
- Wrap and N=0: `acc0_in`=0x7FFFFFFF and `acc1_in`=1 with N=1 give MACC `pcpi_rd`=0x80000000. N=0 gives 256 issue cycles and ready at cycle 259.
- MACZ with the macro defined, `acc0_in`=-5, `acc1_in`=2, N=1 → `pcpi_rd`=0. Without the macro, the same instruction gives `pcpi_wait`=0 and no ready.
- Deassert `pcpi_valid` in cycle 2 of an N=8 run → IDLE next cycle with no ready. `resetn`=0 mid-DRAIN → all outputs at reset values. A new MACC afterwards completes correctly.
- Hold `pcpi_valid` high in the cycle after ready → no relaunch, `pcpi_wait`=0 in that cycle.
